// File: rtl/tap_bus_serializer_if.sv
// Valid/ready stream carrying one tap sample plus its slot index.
// The master drives data and valid; the slave drives ready.
interface tap_bus_serializer_if #(
    parameter int FXP_WIDTH = 16,
    parameter int IDX_W     = 3
);
    logic signed [FXP_WIDTH-1:0] out_sample;
    logic        [IDX_W-1:0]     out_index;
    logic                        out_valid;
    logic                        out_ready;
    logic                        out_last;

    modport master (
        output out_sample,
        output out_index,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_sample,
        input  out_index,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/tap_bus_serializer.sv
// Snapshots the flat tap bus on start and streams the samples one per
// valid/ready transfer, newest-first or oldest-first.
module tap_bus_serializer #(
    parameter int FXP_WIDTH     = 16,
    parameter int FILTER_LENGTH = 8,
    parameter int TAP_BUS_WIDTH = FXP_WIDTH * FILTER_LENGTH,
    parameter int IDX_W         = $clog2(FILTER_LENGTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [TAP_BUS_WIDTH-1:0] buffer_in,
    input  logic                     start,
    input  logic                     reverse_order,
    input  logic                     abort,
    tap_bus_serializer_if.master     ob,
    output logic                     busy,
    output logic                     done,
    output logic                     start_dropped
);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_STREAM = 1'b1;

    localparam logic [IDX_W-1:0] LAST_K = IDX_W'(FILTER_LENGTH - 1);

    logic [0:0]           r_state;
    logic [IDX_W-1:0]     r_k;
    logic                 r_rev;
    logic                 r_done;
    logic                 r_drop;
    logic [FXP_WIDTH-1:0] r_snap [FILTER_LENGTH];

    logic                 w_valid;
    logic                 w_xfer;
    logic                 w_is_last;
    logic [IDX_W-1:0]     w_slot;

    assign w_valid   = (r_state == S_STREAM);
    assign w_xfer    = w_valid && ob.out_ready;
    assign w_is_last = (r_k == LAST_K);
    assign w_slot    = r_rev ? (LAST_K - r_k) : r_k;

    // Data/index are forced to zero outside a stream so idle outputs stay clean.
    assign ob.out_valid  = w_valid;
    assign ob.out_last   = w_valid && w_is_last;
    assign ob.out_index  = w_valid ? w_slot : '0;
    assign ob.out_sample = w_valid ? r_snap[w_slot] : '0;

    assign busy          = w_valid;
    assign done          = r_done;
    assign start_dropped = r_drop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_k     <= '0;
            r_rev   <= 1'b0;
            r_done  <= 1'b0;
            r_drop  <= 1'b0;
            for (int m = 0; m < FILTER_LENGTH; m++) begin
                r_snap[m] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            r_drop <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start && !abort) begin
                        r_state <= S_STREAM;
                        r_k     <= '0;
                        r_rev   <= reverse_order;
                        for (int m = 0; m < FILTER_LENGTH; m++) begin
                            r_snap[m] <= buffer_in[(m+1)*FXP_WIDTH-1 -: FXP_WIDTH];
                        end
                    end
                end
                S_STREAM: begin
                    // Abort outranks both a pending transfer and a new start.
                    if (abort) begin
                        r_state <= S_IDLE;
                        r_k     <= '0;
                    end else begin
                        r_drop <= start;
                        if (w_xfer) begin
                            if (w_is_last) begin
                                r_state <= S_IDLE;
                                r_k     <= '0;
                                r_done  <= 1'b1;
                            end else begin
                                r_k <= r_k + 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_k     <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tap_bus_serializer.sv
// Self-checking bench: directed scenarios plus randomized streams
// compared against a slot-order model of the captured bus.
module tb_tap_bus_serializer;
    localparam int W  = 16;
    localparam int FL = 8;
    localparam int BW = W * FL;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [BW-1:0] buffer_in = '0;
    logic          start = 1'b0;
    logic          rev = 1'b0;
    logic          abort = 1'b0;
    logic          busy;
    logic          done;
    logic          drop;

    int n_vec = 0;
    int n_err = 0;

    logic [W-1:0] m_bus [FL];
    logic [W-1:0] m_cap [FL];
    logic         m_rev;

    tap_bus_serializer_if #(.FXP_WIDTH(W), .IDX_W(IW)) bus ();

    tap_bus_serializer #(
        .FXP_WIDTH(W),
        .FILTER_LENGTH(FL)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .buffer_in(buffer_in),
        .start(start),
        .reverse_order(rev),
        .abort(abort),
        .ob(bus),
        .busy(busy),
        .done(done),
        .start_dropped(drop)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bus();
        for (int m = 0; m < FL; m++) begin
            buffer_in[(m+1)*W-1 -: W] = m_bus[m];
        end
    endtask

    function automatic logic [IW-1:0] exp_slot(input int k, input logic r);
        return r ? IW'(FL - 1 - k) : IW'(k);
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        bus.out_ready = 1'b0;
        #2;
        n_vec++;
        if ({bus.out_valid, bus.out_sample, bus.out_index, bus.out_last,
             busy, done, drop} !== '0) begin
            n_err++;
            $display("FAIL reset outputs got v=%b s=%h i=%0d l=%b b=%b d=%b sd=%b want all 0",
                     bus.out_valid, bus.out_sample, bus.out_index, bus.out_last,
                     busy, done, drop);
        end
        step();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        step();
        step();
        n_vec++;
        if ({bus.out_valid, busy, done} !== 3'b000) begin
            n_err++;
            $display("FAIL reset idle got v=%b b=%b d=%b want 000",
                     bus.out_valid, busy, done);
        end
    endtask

    task automatic test_forward();
        logic [W-1:0] e;
        for (int m = 0; m < FL; m++) m_bus[m] = W'(16'h1000 + m);
        drive_bus();
        bus.out_ready = 1'b1;
        start = 1'b1;
        rev = 1'b0;
        step();
        start = 1'b0;
        for (int k = 0; k < FL; k++) begin
            e = W'(16'h1000 + k);
            n_vec++;
            if ({bus.out_valid, bus.out_sample, bus.out_index, bus.out_last, busy} !==
                {1'b1, e, IW'(k), (k == FL - 1), 1'b1}) begin
                n_err++;
                $display("FAIL fwd k=%0d got v=%b s=%h i=%0d l=%b want s=%h i=%0d l=%b",
                         k, bus.out_valid, bus.out_sample, bus.out_index,
                         bus.out_last, e, k, (k == FL - 1));
            end
            step();
        end
        n_vec++;
        if ({bus.out_valid, busy, done} !== 3'b001) begin
            n_err++;
            $display("FAIL fwd done got v=%b b=%b d=%b want 001",
                     bus.out_valid, busy, done);
        end
        step();
        n_vec++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL fwd done_width got d=%b want 0", done);
        end
    endtask

    task automatic test_reverse_toggle();
        logic         pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic         hold;
        logic [W-1:0] hs;
        logic [IW-1:0] hi;
        logic         hl;
        int           nx;
        int           nd;
        hold = 1'b0;
        hs = '0;
        hi = '0;
        hl = 1'b0;
        nx = 0;
        nd = 0;
        for (int m = 0; m < FL; m++) m_bus[m] = W'(16'h1000 + m);
        drive_bus();
        start = 1'b1;
        rev = 1'b1;
        step();
        start = 1'b0;
        rev = 1'b0;
        for (int c = 0; c < 60 && nd == 0; c++) begin
            if (hold) begin
                n_vec++;
                if ({bus.out_sample, bus.out_index, bus.out_last} !== {hs, hi, hl}) begin
                    n_err++;
                    $display("FAIL rev hold got s=%h i=%0d l=%b want s=%h i=%0d l=%b",
                             bus.out_sample, bus.out_index, bus.out_last, hs, hi, hl);
                end
                hold = 1'b0;
            end
            if (done) nd++;
            bus.out_ready = pat[c % 4];
            if (bus.out_valid) begin
                if (bus.out_ready) begin
                    n_vec++;
                    if (nx >= FL || bus.out_sample !== m_bus[FL - 1 - nx] ||
                        bus.out_index !== exp_slot(nx, 1'b1) ||
                        bus.out_last !== (nx == FL - 1)) begin
                        n_err++;
                        $display("FAIL rev xfer n=%0d got s=%h i=%0d l=%b",
                                 nx, bus.out_sample, bus.out_index, bus.out_last);
                    end
                    nx++;
                end else begin
                    hold = 1'b1;
                    hs = bus.out_sample;
                    hi = bus.out_index;
                    hl = bus.out_last;
                end
            end
            if (nd == 0) step();
        end
        n_vec++;
        if (nx != FL || nd != 1) begin
            n_err++;
            $display("FAIL rev count got xfers=%0d dones=%0d want %0d 1", nx, nd, FL);
        end
        bus.out_ready = 1'b1;
        step();
    endtask

    task automatic test_snapshot();
        logic [W-1:0] e;
        for (int m = 0; m < FL; m++) m_bus[m] = W'(16'h1000 + m);
        drive_bus();
        bus.out_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        buffer_in = '1;
        for (int k = 0; k < FL; k++) begin
            e = W'(16'h1000 + k);
            n_vec++;
            if (bus.out_valid !== 1'b1 || bus.out_sample !== e) begin
                n_err++;
                $display("FAIL snap k=%0d got v=%b s=%h want s=%h",
                         k, bus.out_valid, bus.out_sample, e);
            end
            step();
        end
        n_vec++;
        if (done !== 1'b1) begin
            n_err++;
            $display("FAIL snap done got %b want 1", done);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < FL; k++) begin
            n_vec++;
            if ({bus.out_valid, bus.out_sample, bus.out_index} !==
                {1'b1, 16'hFFFF, IW'(k)}) begin
                n_err++;
                $display("FAIL b2b k=%0d got v=%b s=%h i=%0d want s=ffff i=%0d",
                         k, bus.out_valid, bus.out_sample, bus.out_index, k);
            end
            step();
        end
        n_vec++;
        if (done !== 1'b1) begin
            n_err++;
            $display("FAIL b2b done got %b want 1", done);
        end
        step();
    endtask

    task automatic test_start_drop();
        int nx;
        int nd;
        int ns;
        nx = 0;
        nd = 0;
        ns = 0;
        for (int m = 0; m < FL; m++) m_bus[m] = W'($urandom);
        drive_bus();
        bus.out_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (done) nd++;
            if (drop) ns++;
            start = 1'b0;
            if (bus.out_valid) begin
                n_vec++;
                if (bus.out_sample !== m_bus[nx] || bus.out_index !== exp_slot(nx, 1'b0)) begin
                    n_err++;
                    $display("FAIL drop xfer n=%0d got s=%h i=%0d want s=%h",
                             nx, bus.out_sample, bus.out_index, m_bus[nx]);
                end
                if (nx == 3) start = 1'b1;
                nx++;
            end
            step();
        end
        n_vec++;
        if (nx != FL || nd != 1 || ns != 1) begin
            n_err++;
            $display("FAIL drop count got xfers=%0d dones=%0d drops=%0d want %0d 1 1",
                     nx, nd, ns, FL);
        end
    endtask

    task automatic test_abort();
        int nd;
        nd = 0;
        for (int m = 0; m < FL; m++) m_bus[m] = W'(16'h2000 + m);
        drive_bus();
        bus.out_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 5; k++) step();
        n_vec++;
        if (bus.out_index !== 3'd5) begin
            n_err++;
            $display("FAIL abort pre got i=%0d want 5", bus.out_index);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        n_vec++;
        if ({bus.out_valid, busy, done} !== 3'b000) begin
            n_err++;
            $display("FAIL abort state got v=%b b=%b d=%b want 000",
                     bus.out_valid, busy, done);
        end
        step();
        n_vec++;
        if ({bus.out_valid, done} !== 2'b00) begin
            n_err++;
            $display("FAIL abort nodone got v=%b d=%b want 00", bus.out_valid, done);
        end
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        n_vec++;
        if ({bus.out_valid, drop} !== 2'b00) begin
            n_err++;
            $display("FAIL abort_start got v=%b sd=%b want 00", bus.out_valid, drop);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        n_vec++;
        if ({bus.out_valid, bus.out_sample, bus.out_index} !== {1'b1, 16'h2000, 3'd0}) begin
            n_err++;
            $display("FAIL abort restart got v=%b s=%h i=%0d want s=2000 i=0",
                     bus.out_valid, bus.out_sample, bus.out_index);
        end
        for (int c = 0; c < 12 && nd == 0; c++) begin
            step();
            if (done) nd++;
        end
        n_vec++;
        if (nd != 1) begin
            n_err++;
            $display("FAIL abort drain got dones=%0d want 1", nd);
        end
        step();
    endtask

    task automatic test_async_reset();
        logic seen;
        seen = 1'b0;
        for (int m = 0; m < FL; m++) m_bus[m] = W'($urandom) | 16'h0001;
        drive_bus();
        bus.out_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        n_vec++;
        if (bus.out_index !== 3'd2) begin
            n_err++;
            $display("FAIL areset pre got i=%0d want 2", bus.out_index);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({bus.out_valid, bus.out_sample, bus.out_index, bus.out_last,
             busy, done, drop} !== '0) begin
            n_err++;
            $display("FAIL areset outputs got v=%b s=%h i=%0d b=%b d=%b",
                     bus.out_valid, bus.out_sample, bus.out_index, busy, done);
        end
        #4;
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            if (bus.out_valid || busy || done || drop) seen = 1'b1;
        end
        n_vec++;
        if (seen !== 1'b0) begin
            n_err++;
            $display("FAIL areset quiet got activity=%b want 0", seen);
        end
    endtask

    task automatic test_random();
        logic         hold;
        logic [W-1:0] hs;
        logic [IW-1:0] hi;
        logic         exp_drop;
        int           nx;
        int           nd;
        for (int it = 0; it < 20; it++) begin
            for (int m = 0; m < FL; m++) m_bus[m] = W'($urandom);
            drive_bus();
            m_rev = 1'($urandom);
            rev = m_rev;
            m_cap = m_bus;
            start = 1'b1;
            step();
            start = 1'b0;
            buffer_in = {$urandom, $urandom, $urandom, $urandom};
            hold = 1'b0;
            hs = '0;
            hi = '0;
            exp_drop = 1'b0;
            nx = 0;
            nd = 0;
            for (int c = 0; c < 80 && nd == 0; c++) begin
                n_vec++;
                if (drop !== exp_drop) begin
                    n_err++;
                    $display("FAIL rnd drop it=%0d got %b want %b", it, drop, exp_drop);
                end
                if (hold) begin
                    n_vec++;
                    if ({bus.out_sample, bus.out_index} !== {hs, hi}) begin
                        n_err++;
                        $display("FAIL rnd hold it=%0d got s=%h i=%0d want s=%h i=%0d",
                                 it, bus.out_sample, bus.out_index, hs, hi);
                    end
                end
                hold = 1'b0;
                if (done) nd++;
                if (nd != 0) begin
                    start = 1'b0;
                end else begin
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                    start = ($urandom_range(0, 9) == 0);
                    exp_drop = start && bus.out_valid;
                    if (bus.out_valid && bus.out_ready) begin
                        n_vec++;
                        if (nx >= FL ||
                            bus.out_sample !== m_cap[exp_slot(nx, m_rev)] ||
                            bus.out_index !== exp_slot(nx, m_rev) ||
                            bus.out_last !== (nx == FL - 1)) begin
                            n_err++;
                            $display("FAIL rnd xfer it=%0d n=%0d got s=%h i=%0d l=%b",
                                     it, nx, bus.out_sample, bus.out_index, bus.out_last);
                        end
                        nx++;
                    end else if (bus.out_valid) begin
                        hold = 1'b1;
                        hs = bus.out_sample;
                        hi = bus.out_index;
                    end
                    step();
                end
            end
            n_vec++;
            if (nx != FL || nd != 1 || bus.out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL rnd end it=%0d got xfers=%0d dones=%0d v=%b",
                         it, nx, nd, bus.out_valid);
            end
            if ($urandom_range(0, 1) == 0) step();
        end
    endtask

    initial begin
        bus.out_ready = 1'b0;
        for (int m = 0; m < FL; m++) m_bus[m] = '0;
        m_cap = m_bus;
        m_rev = 1'b0;
        test_reset();
        test_forward();
        test_reverse_toggle();
        test_snapshot();
        test_start_drop();
        test_abort();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tap_bus_serializer.md
Name: tap_bus_serializer

Overview:
- Reader for the output-history tap bus. The history shift register writes FILTER_LENGTH samples onto one flat bus; this block reads them back one at a time.
- On a start pulse it captures a snapshot of the bus. It then streams the samples one per handshake on a valid/ready interface.
- Used for debug readout, coefficient/history export and the downstream serial update logic.
- The snapshot is fully decoupled from further bus changes.

Parameters:
- FXP_WIDTH, 16, width of one signed fixed-point sample.
- FILTER_LENGTH, 8, number of samples on the tap bus (at least 2).
- TAP_BUS_WIDTH, FXP_WIDTH*FILTER_LENGTH, flat bus width. Slot m occupies bits [(m+1)*FXP_WIDTH-1 -: FXP_WIDTH]. Slot 0 is the newest sample.
- IDX_W, $clog2(FILTER_LENGTH), width of the index output.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- buffer_in  input  TAP_BUS_WIDTH  tap bus from the history shift register.
- start  input  1  request a snapshot and stream; level sampled each cycle.
- reverse_order  input  1  0 = newest first (slot 0 upward), 1 = oldest first (slot FILTER_LENGTH-1 downward). Sampled with start.
- abort  input  1  synchronous flush of an in-progress stream.
- out_sample  output  FXP_WIDTH (signed)  current sample.
- out_index  output  IDX_W  slot number of out_sample.
- out_valid  output  1  out_sample is valid.
- out_ready  input  1  consumer accepts.
- out_last  output  1  current element is the final one of the stream.
- busy  output  1  high while in STREAM.
- done  output  1  one-cycle pulse after the final transfer.
- start_dropped  output  1  one-cycle pulse when a start is ignored.

Behaviour:
- Reset: all outputs are 0, the state is IDLE and the snapshot registers are cleared. Reset applies asynchronously at any time, including mid-stream. There is no done pulse after reset.
- States:
  - IDLE: waits for start.
  - STREAM: presents elements.
- IDLE to STREAM when start=1 and abort=0. On that edge:
  - buffer_in is latched into the snapshot array.
  - reverse_order is latched.
  - the element counter k is set to 0.
- Latency: out_valid is high in the cycle after start is accepted.
  - Element k maps to slot k when the latched order is 0.
  - Element k maps to slot FILTER_LENGTH-1-k when the latched order is 1.
  - out_index is the slot number.
- Handshake:
  - A transfer occurs on an edge where out_valid and out_ready are both 1.
  - While out_valid=1 and out_ready=0, out_sample, out_index and out_last hold stable.
  - out_valid never drops without a transfer, except on abort or reset.
  - out_ready may be high before out_valid; it has no effect in IDLE.
- Throughput is one element per cycle when out_ready is held high. FILTER_LENGTH transfers take exactly FILTER_LENGTH cycles.
- out_last = out_valid and (k == FILTER_LENGTH-1).
- Final transfer:
  - The state returns to IDLE, out_valid and busy go to 0, and done=1 for one cycle.
  - A start asserted in that done cycle is accepted, so streams can run back-to-back with a one-cycle bubble.
- start while busy (not aborting): ignored. start_dropped pulses for one cycle; the stream continues unchanged.
- abort in STREAM: next state is IDLE with out_valid=0 and busy=0. There is no done pulse and no partial-transfer completion. The counter and snapshot data are discarded.
  - abort has priority over a simultaneous handshake.
  - abort with start in the same cycle: abort wins and start is not accepted. start_dropped does not pulse.
- abort in IDLE: no effect.
- No arithmetic on data. Samples pass bit-exact, sign preserved.
- Changes on buffer_in after capture never affect the stream in progress.

Test Plan:
- Reset, then slot m = 16'h1000+m, start with reverse_order=0 and out_ready=1 constant -> out_valid rises the cycle after start. 8 consecutive transfers with samples 1000..1007 and index 0..7. out_last only on 1007. done pulses one cycle after, busy=0.
- Same bus with reverse_order=1 and out_ready toggling 1,0,0,1,... -> order 1007 down to 1000. Data and index hold during ready=0 cycles. Exactly 8 transfers, then done.
- Capture, then overwrite buffer_in with all 16'hFFFF mid-stream -> the stream still emits 1000..1007. A new start in the done cycle captures FFFF values with no lost cycle beyond the bubble.
- start pulsed at element 3 of an active stream -> start_dropped pulses once. The stream completes 8 elements unchanged and done pulses once.
- abort asserted together with out_ready at element 5 -> element 5 is not counted as transferred. Next cycle out_valid=0, busy=0, no done. A subsequent start streams from slot 0 again.
- rst_n dropped asynchronously mid-cycle during element 2 -> all outputs are 0 immediately. After release, no activity until a new start.
